score_display_scan: RTL and testbench
=====================================

Name: score_display_scan

Overview:
- Downstream consumer of the score counter's six BCD digit outputs.
- Drives the board's 4-digit multiplexed seven-segment display, scanning one digit at a time.
- Shows the current score while playing; on game over, alternates between the current score and the high score, marking the high score with an 'H' in the leftmost digit.
- Latches digit values once per scan frame so a changing score never tears mid-frame.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (>=2)
ALT_PERIOD, 200, scan frames per display phase in game-over alternation (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
game_over  input  1  1 = alternate score/high score; 0 = show score only
score1  input  4  current score units digit
score2  input  4  current score tens digit
score3  input  4  current score hundreds digit (can reach 10)
high_score1  input  4  high score units digit
high_score2  input  4  high score tens digit
high_score3  input  4  high score hundreds digit (can reach 10)
an  output  4  digit enables, active-low; an[0] = rightmost digit
seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g..a

Behaviour:
- Reset is asynchronous and active-high; it only clears state.
- Reset values:
  - prescaler = 0, idx = 0, frame_cnt = 0, mode = SHOW_SCORE.
  - Snapshot digits = 0, snap_mode = SHOW_SCORE.
  - an = 4'b1111, seg = 8'hFF.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index idx (2 bits) increments on tick: 0->1->2->3->0.
- Frame boundary = tick with idx==3. At a frame boundary:
  - If game_over=1: if frame_cnt==ALT_PERIOD-1, then frame_cnt<=0 and mode toggles; else frame_cnt<=frame_cnt+1.
  - snap_mode <= the mode value for the new frame (after any toggle).
  - Snapshot digits <= score* if that mode is SHOW_SCORE, else high_score*.
- When game_over=0: every cycle, mode<=SHOW_SCORE and frame_cnt<=0. snap_mode follows only at the next frame boundary.
- Input digits are sampled only at frame boundaries; changes mid-frame are invisible until the next frame.
- Outputs are registered every cycle from the current idx, snapshot and snap_mode (1-cycle latency):
  - an = one-cold at bit idx.
  - seg[7] = 1 always (dp off).
- Digit content by idx:
  - 0: units, always shown.
  - 1: tens; blank if hundreds==0 and tens==0.
  - 2: hundreds; blank if hundreds==0.
  - 3: blank in SHOW_SCORE; 'H' in SHOW_HIGH.
- seg codes, dp included:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any value 10..15 shows '-' = BF.
  - Blank = FF, 'H' = 89.
- Leading-zero blanking is judged on the raw value: hundreds==10 is non-zero and shows BF.
- Reset mid-frame: all outputs return immediately (asynchronously) to their reset values. After release the scan restarts at idx 0 with a zero snapshot.

Test Plan:
(All with SCAN_DIV=4, ALT_PERIOD=2.)
- Reset: assert reset mid-scan -> an=1111, seg=FF at once. Release -> next edge an=1110, seg=C0; an steps 1101, 1011, 0111 every 4 cycles.
- Snapshot and blanking: score=1,2,3 (h,t,u), game_over=0 -> from the frame after the boundary: an 1110 seg B0, 1101 A4, 1011 F9, 0111 FF.
- Leading zeros:
  - score 0,0,7 -> F8, FF, FF, FF.
  - score 0,5,0 -> C0, 92, FF, FF.
- Tearing: change score from 0,0,7 to 0,0,8 during idx=1 -> remaining digits of that frame unchanged. Next frame units = 80.
- Alternation: game_over=1, score 0,0,4, high 0,1,2 -> 2 frames of 99, FF, FF, FF, then 2 frames of A4, F9, FF, 89, repeating. Drop game_over mid high-score frame -> next frame shows score.
- Overflow digit: score3=10, score2=2, score1=3 -> B0, A4, BF, FF.

Source files
------------

// File: rtl/score_display_scan.sv
// Scans six score BCD digits onto a 4-digit multiplexed 7-seg display.
// Ports: clk, reset (async high), game_over, score1..3, high_score1..3 in;
//   an[3:0] (active-low digit enables), seg[7:0] (active-low dp,g..a) out.
module score_display_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int ALT_PERIOD = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_over,
  input  logic [3:0] score1,
  input  logic [3:0] score2,
  input  logic [3:0] score3,
  input  logic [3:0] high_score1,
  input  logic [3:0] high_score2,
  input  logic [3:0] high_score3,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (ALT_PERIOD > 2) ? $clog2(ALT_PERIOD) : 1;

  typedef enum logic {
    SHOW_SCORE = 1'b0,
    SHOW_HIGH  = 1'b1
  } mode_t;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [FW-1:0] r_cnt;
  mode_t         r_mode;
  mode_t         r_snap_mode;
  logic [3:0]    r_u;
  logic [3:0]    r_t;
  logic [3:0]    r_h;

  logic          w_tick;
  logic          w_frame;
  logic [FW-1:0] w_cnt_nxt;
  mode_t         w_mode_nxt;
  logic [7:0]    w_seg;

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  assign w_tick  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_frame = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick)
        r_idx <= r_idx + 2'd1;
    end
  end

  // Mode for the next cycle; at a frame boundary this is also
  // the mode the new frame is rendered in.
  always_comb begin
    w_mode_nxt = r_mode;
    w_cnt_nxt  = r_cnt;
    if (!game_over) begin
      w_mode_nxt = SHOW_SCORE;
      w_cnt_nxt  = '0;
    end else if (w_frame) begin
      if (r_cnt == FW'(ALT_PERIOD - 1)) begin
        w_cnt_nxt  = '0;
        w_mode_nxt = (r_mode == SHOW_SCORE) ? SHOW_HIGH : SHOW_SCORE;
      end else begin
        w_cnt_nxt = r_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_mode <= SHOW_SCORE;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mode <= w_mode_nxt;
    end
  end

  // Snapshot once per frame so a changing score never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_mode <= SHOW_SCORE;
      r_u         <= '0;
      r_t         <= '0;
      r_h         <= '0;
    end else if (w_frame) begin
      r_snap_mode <= w_mode_nxt;
      if (w_mode_nxt == SHOW_SCORE) begin
        r_u <= score1;
        r_t <= score2;
        r_h <= score3;
      end else begin
        r_u <= high_score1;
        r_t <= high_score2;
        r_h <= high_score3;
      end
    end
  end

  // Blanking is judged on raw values, so a hundreds of 10 still shows.
  always_comb begin
    w_seg = 8'hFF;
    case (r_idx)
      2'd0: w_seg = f_seg(r_u);
      2'd1: if (!(r_h == 4'd0 && r_t == 4'd0)) w_seg = f_seg(r_t);
      2'd2: if (r_h != 4'd0) w_seg = f_seg(r_h);
      default: if (r_snap_mode == SHOW_HIGH) w_seg = 8'h89;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with SCAN_DIV=4, ALT_PERIOD=2.
// Each frame is 16 cycles; inputs set at a frame start show next frame.
module tb_score_display_scan;

  logic       clk;
  logic       reset;
  logic       game_over;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] score3;
  logic [3:0] high_score1;
  logic [3:0] high_score2;
  logic [3:0] high_score3;
  logic [3:0] an;
  logic [7:0] seg;

  int n_checks = 0;
  int n_err    = 0;

  score_display_scan #(
    .SCAN_DIV  (4),
    .ALT_PERIOD(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .game_over  (game_over),
    .score1     (score1),
    .score2     (score2),
    .score3     (score3),
    .high_score1(high_score1),
    .high_score2(high_score2),
    .high_score3(high_score3),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] ea,
                     input logic [7:0] es);
    n_checks++;
    assert ({an, seg} === {ea, es}) else begin
      n_err++;
      $error("FAIL %s an=%b seg=%h expected an=%b seg=%h",
             tag, an, seg, ea, es);
    end
  endtask

  task automatic set_sc(input logic [3:0] h,
                        input logic [3:0] t,
                        input logic [3:0] u);
    score3 = h;
    score2 = t;
    score1 = u;
  endtask

  // Called just after the first edge of a frame; returns 16 cycles on.
  task automatic frame(input string tag,
                       input logic [7:0] d0,
                       input logic [7:0] d1,
                       input logic [7:0] d2,
                       input logic [7:0] d3);
    chk({tag, "_d0"}, 4'b1110, d0);
    tick(4);
    chk({tag, "_d1"}, 4'b1101, d1);
    tick(4);
    chk({tag, "_d2"}, 4'b1011, d2);
    tick(4);
    chk({tag, "_d3"}, 4'b0111, d3);
    tick(4);
  endtask

  initial begin
    reset       = 1'b0;
    game_over   = 1'b0;
    set_sc(4'd0, 4'd0, 4'd0);
    high_score3 = 4'd0;
    high_score2 = 4'd1;
    high_score1 = 4'd2;

    #2 reset = 1'b1;
    #1 chk("reset_async", 4'b1111, 8'hFF);
    tick(3);
    chk("reset_hold", 4'b1111, 8'hFF);
    reset = 1'b0;
    tick(1);

    set_sc(4'd1, 4'd2, 4'd3);
    frame("f0_zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    set_sc(4'd0, 4'd0, 4'd7);
    frame("f1_123", 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    chk("f2_007_d0", 4'b1110, 8'hF8);
    tick(4);
    set_sc(4'd0, 4'd0, 4'd8);
    chk("f2_tear_d1", 4'b1101, 8'hFF);
    tick(4);
    chk("f2_tear_d2", 4'b1011, 8'hFF);
    tick(4);
    chk("f2_tear_d3", 4'b0111, 8'hFF);
    tick(4);

    set_sc(4'd0, 4'd5, 4'd0);
    frame("f3_008", 8'h80, 8'hFF, 8'hFF, 8'hFF);

    set_sc(4'd10, 4'd2, 4'd3);
    frame("f4_050", 8'hC0, 8'h92, 8'hFF, 8'hFF);

    set_sc(4'd0, 4'd0, 4'd4);
    game_over = 1'b1;
    frame("f5_ovf", 8'hB0, 8'hA4, 8'hBF, 8'hFF);

    frame("f6_score", 8'h99, 8'hFF, 8'hFF, 8'hFF);
    frame("f7_high", 8'hA4, 8'hF9, 8'hFF, 8'h89);
    frame("f8_high", 8'hA4, 8'hF9, 8'hFF, 8'h89);
    frame("f9_score", 8'h99, 8'hFF, 8'hFF, 8'hFF);
    frame("f10_score", 8'h99, 8'hFF, 8'hFF, 8'hFF);

    chk("f11_high_d0", 4'b1110, 8'hA4);
    tick(4);
    game_over = 1'b0;
    chk("f11_drop_d1", 4'b1101, 8'hF9);
    tick(4);
    chk("f11_drop_d2", 4'b1011, 8'hFF);
    tick(4);
    chk("f11_drop_d3", 4'b0111, 8'h89);
    tick(4);

    chk("f12_score_d0", 4'b1110, 8'h99);
    tick(6);
    reset = 1'b1;
    #1 chk("reset_mid", 4'b1111, 8'hFF);
    tick(2);
    chk("reset_mid_hold", 4'b1111, 8'hFF);
    reset = 1'b0;
    tick(1);
    frame("post_rst", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    frame("post_rst_sc", 8'h99, 8'hFF, 8'hFF, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
